// File: rtl/lza_pipe.sv
// Two-stage leading-zero anticipator with valid/ready handshake on both sides.
// Optional macro LZA_CORR_EN adds the exact sum count and the Corr_SO mismatch flag.
module lza_pipe #(
  parameter int unsigned C_WIDTH         = 74,
  parameter int unsigned C_LEADONE_WIDTH = 7
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RI,
  input  logic [C_WIDTH-1:0]         A_DI,
  input  logic [C_WIDTH-1:0]         B_DI,
  input  logic                       Valid_SI,
  output logic                       Ready_SO,
  output logic [C_LEADONE_WIDTH-1:0] Leading_one_DO,
  output logic                       No_one_SO,
  output logic                       Corr_SO,
  output logic                       Valid_SO,
  input  logic                       Ready_SI
);

  localparam int unsigned W  = C_WIDTH;
  localparam int unsigned LW = C_LEADONE_WIDTH;

  // Zeros above the most significant set bit; 0 for an all-zero vector.
  function automatic logic [LW-1:0] lz_count(input logic [W-1:0] v);
    logic [LW-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (v[i]) cnt = LW'(W - 1 - i);
    end
    return cnt;
  endfunction

  logic [W-1:0] t, g, z, f;

  // Indicator vector from the propagate/generate/kill bits of the operands.
  always_comb begin
    t = A_DI ^ B_DI;
    g = A_DI & B_DI;
    z = ~(A_DI | B_DI);
    f = '0;
    f[W-1] = ~t[W-1] & t[W-2];
    for (int unsigned j = 1; j < W - 1; j++) begin
      f[j] = (t[j+1] & ((g[j] & ~z[j-1]) | (z[j] & ~g[j-1]))) |
             (~t[j+1] & ((z[j] & ~z[j-1]) | (g[j] & ~g[j-1])));
    end
    f[0] = (t[1] & z[0]) | (~t[1] & (t[0] | g[0]));
  end

  logic         s1_valid;
  logic [W-1:0] s1_f;
  logic         s2_valid;
  logic         s2_adv;
  logic         accept;
  logic [LW-1:0] lo_q;
  logic          no_one_q;

  assign s2_adv   = ~s2_valid | Ready_SI;
  assign Ready_SO = ~s1_valid | s2_adv;
  assign accept   = Valid_SI & Ready_SO;

  assign Valid_SO       = s2_valid;
  assign Leading_one_DO = lo_q;
  assign No_one_SO      = no_one_q;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      lo_q     <= '0;
      no_one_q <= 1'b0;
    end else begin
      if (Ready_SO) s1_valid <= Valid_SI;
      if (s2_adv)   s2_valid <= s1_valid;
      if (s1_valid && s2_adv) begin
        lo_q     <= lz_count(s1_f);
        no_one_q <= ~|s1_f;
      end
    end
  end

  // Stage-1 payload only loads on an accepted input, so idle cycles leave it untouched.
  always_ff @(posedge Clk_CI) begin
    if (accept) s1_f <= f;
  end

`ifdef LZA_CORR_EN
  logic [W-1:0] s1_sum;
  logic         corr_q;

  always_ff @(posedge Clk_CI) begin
    if (accept) s1_sum <= A_DI + B_DI;
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      corr_q <= 1'b0;
    end else if (s1_valid && s2_adv) begin
      corr_q <= (lz_count(s1_sum) != lz_count(s1_f));
    end
  end

  assign Corr_SO = corr_q;
`else
  assign Corr_SO = 1'b0;
`endif

endmodule
